// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: two combinational read ports, one write port,
// optional bypass and zero register, per-register pending scoreboard and a post-reset clear engine.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              ready,
  output logic              any_pend
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [WIDTH-1:0]  ZERO_DATA = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_nxt_s;
  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH-1:0]  pend_r, pend_nxt_s;
  logic              run_s, wr_ok_s, rsv_ok_s;

  // Qualified write/reserve strobes: only in RUN, never during reset, never on the zero register
  always_comb begin
    run_s    = (state_r == RUN);
    wr_ok_s  = run_s && !rst && wr_en
               && !((ZERO_REG != 0) && (wr_addr == ZERO_ADDR));
    rsv_ok_s = run_s && !rst && rsv_en
               && !((ZERO_REG != 0) && (rsv_addr == ZERO_ADDR));
  end

  // Clear-engine sequencing: sweep every address once, then enter RUN
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt_s   = RUN;
          clr_cnt_nxt_s = ZERO_ADDR;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
        end
      end
      RUN: begin
        state_nxt_s   = RUN;
        clr_cnt_nxt_s = ZERO_ADDR;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_cnt_nxt_s = ZERO_ADDR;
      end
    endcase
  end

  // State and clear counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_cnt_r <= ZERO_ADDR;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Storage array: the clear engine owns the write port until RUN
  always_ff @(posedge clk) begin
    if (!rst && (state_r == CLEAR)) begin
      mem_r[clr_cnt_r] <= ZERO_DATA;
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // A new reservation outranks a completing write to the same register
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 0; i < DEPTH; i++) begin
      pend_nxt_s[i] = (rsv_ok_s && (rsv_addr == ADDR_W'(i))) ? 1'b1 :
                      (wr_ok_s  && (wr_addr  == ADDR_W'(i))) ? 1'b0 :
                      pend_r[i];
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Read port 1: zero register beats bypass beats array
  always_comb begin
    if (!run_s) begin
      rd_data1 = ZERO_DATA;
    end else if ((ZERO_REG != 0) && (rd_addr1 == ZERO_ADDR)) begin
      rd_data1 = ZERO_DATA;
    end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = mem_r[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    if (!run_s) begin
      rd_data2 = ZERO_DATA;
    end else if ((ZERO_REG != 0) && (rd_addr2 == ZERO_ADDR)) begin
      rd_data2 = ZERO_DATA;
    end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = mem_r[rd_addr2];
    end
  end

  // Status outputs; pending bits are deliberately not bypassed
  always_comb begin
    ready    = run_s;
    rd_pend1 = run_s & pend_r[rd_addr1];
    rd_pend2 = run_s & pend_r[rd_addr2];
    any_pend = run_s & (|pend_r);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: table of read/write/reserve vectors plus
// hand-written reset and clear sequences; a BYPASS=0 twin shares all inputs.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic        wr_en, rsv_en;
  logic [31:0] rd_data1, rd_data2, nb_d1, nb_d2;
  logic        rd_pend1, rd_pend2, ready, any_pend;
  logic        nb_p1, nb_p2, nb_ready, nb_any;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(ready), .any_pend(any_pend)
  );

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_d1), .rd_data2(nb_d2),
    .rd_pend1(nb_p1), .rd_pend2(nb_p2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(nb_ready), .any_pend(nb_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_p1;
    logic        e_p2;
    logic        e_any;
    logic [31:0] e_nb1;
    logic [31:0] e_nb2;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rsv_en = 1'b0; rsv_addr = 5'd0;
  endtask

  // Expect ready low for exactly 32 cycles after the reset edge, then high
  task automatic check_clear(input string tag);
    for (int i = 0; i < 32; i++) begin
      #2;
      chk($sformatf("%s ready_low[%0d]", tag, i), {31'd0, ready}, 32'd0);
      chk($sformatf("%s rd_data1_clear[%0d]", tag, i), rd_data1, 32'h0);
      tick();
    end
    #2;
    chk($sformatf("%s ready_high", tag), {31'd0, ready}, 32'd1);
    chk($sformatf("%s nb_ready_high", tag), {31'd0, nb_ready}, 32'd1);
  endtask

  // Every register must read 0 and be non-pending
  task automatic check_all_zero(input string tag);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #2;
      chk($sformatf("%s d1[%0d]", tag, i), rd_data1, 32'h0);
      chk($sformatf("%s d2[%0d]", tag, 31 - i), rd_data2, 32'h0);
      chk($sformatf("%s p1[%0d]", tag, i), {31'd0, rd_pend1}, 32'd0);
      tick();
    end
    chk($sformatf("%s any_pend", tag), {31'd0, any_pend}, 32'd0);
  endtask

  initial begin
    //        wr  wa     wdata          rsv ra    rd1    rd2    e_d1           e_d2           p1    p2    any   nb1            nb2
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd31, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7,  5'd0,  32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9,  5'd7,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0,        32'hA5A5A5A5};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 5'd9,  5'd0,  32'h00000099, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd0,  32'h00000099, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000099, 32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 5'd3, 32'h00000033, 1'b1, 5'd3, 5'd3,  5'd0,  32'h00000033, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 5'd3, 32'h00003333, 1'b1, 5'd4, 5'd3,  5'd4,  32'h00003333, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00000033, 32'h0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd4,  32'h00003333, 32'h0,        1'b0, 1'b1, 1'b1, 32'h00003333, 32'h0};
    vecs[13] = '{1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 5'd4,  5'd4,  32'h00000044, 32'h00000044, 1'b1, 1'b1, 1'b1, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4,  5'd5,  32'h00000044, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h00000044, 32'hDEADBEEF};

    idle_inputs();
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Writes and reservations during the clear sweep must be dropped
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    rd_addr1 = 5'd5;
    check_clear("init");
    check_all_zero("init");

    for (int v = 0; v < 15; v++) begin
      wr_en    = vecs[v].wr_en;
      wr_addr  = vecs[v].wr_addr;
      wr_data  = vecs[v].wr_data;
      rsv_en   = vecs[v].rsv_en;
      rsv_addr = vecs[v].rsv_addr;
      rd_addr1 = vecs[v].ra1;
      rd_addr2 = vecs[v].ra2;
      #2;
      chk($sformatf("v%0d rd_data1", v), rd_data1, vecs[v].e_d1);
      chk($sformatf("v%0d rd_data2", v), rd_data2, vecs[v].e_d2);
      chk($sformatf("v%0d rd_pend1", v), {31'd0, rd_pend1}, {31'd0, vecs[v].e_p1});
      chk($sformatf("v%0d rd_pend2", v), {31'd0, rd_pend2}, {31'd0, vecs[v].e_p2});
      chk($sformatf("v%0d any_pend", v), {31'd0, any_pend}, {31'd0, vecs[v].e_any});
      chk($sformatf("v%0d nb_rd_data1", v), nb_d1, vecs[v].e_nb1);
      chk($sformatf("v%0d nb_rd_data2", v), nb_d2, vecs[v].e_nb2);
      chk($sformatf("v%0d nb_pend1", v), {31'd0, nb_p1}, {31'd0, vecs[v].e_p1});
      chk($sformatf("v%0d nb_pend2", v), {31'd0, nb_p2}, {31'd0, vecs[v].e_p2});
      chk($sformatf("v%0d nb_any", v), {31'd0, nb_any}, {31'd0, vecs[v].e_any});
      tick();
    end

    // Reset from RUN with r9 pending and r5 holding data, re-reset at clr_cnt=10
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle_inputs();
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd5;
    #2;
    chk("pre_rst pend9", {31'd0, rd_pend1}, 32'd1);
    chk("pre_rst r5", rd_data2, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    chk("mid_clear ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_clear("restart");
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd9;
    #2;
    chk("post_rst r5", rd_data1, 32'h0);
    chk("post_rst pend9", {31'd0, rd_pend2}, 32'd0);
    check_all_zero("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the MIPS register file. Provides two asynchronous read ports and one synchronous write port, with configurable data width and register count. Adds optional write-to-read bypass, an optional hard-wired zero register, a per-register pending-write scoreboard for pipeline hazard detection, and a sequential clear engine that zeroes every register after reset. Sits in the decode stage, fed by the writeback stage.

Parameters:
WIDTH, 32, data width in bits.
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
ZERO_REG, 1, if 1 then register 0 reads 0, ignores writes and is never marked pending.
BYPASS, 1, if 1 then a same-cycle write is forwarded to a matching read port.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
rd_addr1  in  ADDR_W  read port 1 address.
rd_addr2  in  ADDR_W  read port 2 address.
rd_data1  out  WIDTH  read port 1 data (combinational).
rd_data2  out  WIDTH  read port 2 data (combinational).
rd_pend1  out  1  pending bit of rd_addr1 (combinational).
rd_pend2  out  1  pending bit of rd_addr2 (combinational).
wr_en  in  1  write enable.
wr_addr  in  ADDR_W  write address.
wr_data  in  WIDTH  write data.
rsv_en  in  1  reserve: mark rsv_addr pending (a producer has issued).
rsv_addr  in  ADDR_W  register to reserve.
ready  out  1  1 when the clear engine is done and the block is usable.
any_pend  out  1  OR of all pending bits.

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- FSM states: CLEAR, RUN.
- Reset: rst=1 at an edge -> state=CLEAR, clr_cnt=0, all pending bits=0. Takes priority over every other input. Assertion mid-CLEAR restarts clr_cnt at 0.
- CLEAR:
  - Each cycle writes 0 to reg[clr_cnt], then clr_cnt+1.
  - When clr_cnt == DEPTH-1 has been written -> RUN.
  - Clear time is DEPTH cycles after rst deasserts (32 for the default configuration).
  - ready=0. wr_en and rsv_en are ignored. rd_data1/2=0, rd_pend1/2=0, any_pend=0.
- RUN: ready=1.
- Write:
  - wr_en=1 -> reg[wr_addr] <= wr_data at the edge, visible on reads in the next cycle.
  - The same edge clears pend[wr_addr].
  - With ZERO_REG=1 and wr_addr=0: no effect.
- Read:
  - rd_dataN = reg[rd_addrN].
  - ZERO_REG=1 and rd_addrN=0 -> 0.
  - BYPASS=1 and wr_en=1 and wr_addr==rd_addrN (not a zero-reg hit) -> rd_dataN = wr_data in the same cycle.
  - Priority: zero-reg > bypass > array.
- Scoreboard:
  - rsv_en=1 -> pend[rsv_addr] <= 1.
  - Same cycle wr_en and rsv_en on the same address -> pending=1 (new reservation wins over the old producer's completion); data is still written.
  - Different addresses -> both actions apply independently.
  - ZERO_REG=1 and rsv_addr=0 -> ignored.
  - rd_pendN = pend[rd_addrN], not bypassed: a write in this cycle still shows pending until the edge.
  - any_pend = OR of pend[DEPTH-1:0].
- Widths: no arithmetic except clr_cnt, which is ADDR_W bits. Terminal detection uses the count value, not wrap-around.
- No reads or writes during CLEAR, so no stale power-up X ever reaches a read port once ready=1.

Test Plan:
- Reset/clear: pulse rst 1 cycle -> ready=0 for exactly 32 cycles, then 1. After ready, reads of regs 0..31 all return 0. wr_en asserted during CLEAR -> no effect.
- Basic write/read: write 0xDEADBEEF to r5 -> next cycle rd_addr1=5 gives 0xDEADBEEF. Write 0x1234 to r0 -> rd_addr2=0 still returns 0 (ZERO_REG=1).
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr1=7 -> rd_data1=0xA5A5A5A5 combinationally. With BYPASS=0 -> old value (0).
- Scoreboard:
  - rsv r9 -> next cycle rd_pend1=1 at rd_addr1=9, any_pend=1.
  - Write r9 -> rd_pend1=1 in the write cycle, then 0 and any_pend=0.
  - Reserve r0 -> rd_pend stays 0.
- Simultaneous: wr_en and rsv_en both on r3 in one cycle -> r3 data updated and pend[3]=1 afterwards. Different addresses r3/r4 -> pend[3]=0, pend[4]=1.
- Reset mid-operation: rst at clr_cnt=10 -> clear restarts, ready after 32 further cycles. rst in RUN with pend[9]=1 and r5=0xDEADBEEF -> after clear, pend all 0 and r5 reads 0.
